// File: rtl/msg_cipher_pkg.sv
// msg_cipher_pkg: shared types and round/key-schedule helpers for the Feistel
// encryptor (msg_encryptor) and its decryptor counterpart.
package msg_cipher_pkg;

    localparam int ROUND_W = 32;
    localparam int KEY_W   = 64;

    typedef logic [2*ROUND_W-1:0] block_t;
    typedef logic [ROUND_W-1:0]   half_t;
    typedef logic [KEY_W-1:0]     key_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // F(R,k) = rotl(R ^ k, 3) + k, modulo 2^32
    function automatic half_t round_f(input half_t r, input half_t k);
        half_t x_s;
        x_s = r ^ k;
        return {x_s[ROUND_W-4:0], x_s[ROUND_W-1:ROUND_W-3]} + k;
    endfunction

    // Low half of the key rotated left by 4*i; the rotation wraps modulo 64
    function automatic half_t subkey(input key_t k, input logic [4:0] i);
        logic [5:0] amt_s;
        amt_s = 6'({i, 2'b00});
        return half_t'({k, k} >> (7'd64 - {1'b0, amt_s}));
    endfunction

endpackage

// File: rtl/msg_feistel_round.sv
// msg_feistel_round: one combinational Feistel round (L,R,k -> L',R').
// Shared between the encryptor and the decryptor, which differ only in subkey order.
module msg_feistel_round
    import msg_cipher_pkg::*;
(
    input  logic [ROUND_W-1:0] l,
    input  logic [ROUND_W-1:0] r,
    input  logic [ROUND_W-1:0] k,
    output logic [ROUND_W-1:0] l_next,
    output logic [ROUND_W-1:0] r_next
);

    // Swap halves and fold F(right, subkey) into the old left half
    always_comb begin
        l_next = r;
        r_next = l ^ round_f(r, k);
    end

endmodule

// File: rtl/msg_encryptor.sv
// msg_encryptor: iterative 64-bit Feistel encryptor, one round per clock, valid/ready on both sides.
// Optional macro MSG_ENCRYPTOR_CBC_EN: chain each plaintext with the previous ciphertext (CBC); default ECB.
module msg_encryptor
    import msg_cipher_pkg::*;
#(
    parameter int ROUNDS = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*ROUND_W-1:0] message,
    input  logic [KEY_W-1:0]   key,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*ROUND_W-1:0] encrypted_msg,
    output logic               busy
);

    localparam logic [1:0] S_IDLE   = 2'(IDLE);
    localparam logic [1:0] S_RUN    = 2'(RUN);
    localparam logic [1:0] S_DONE   = 2'(DONE);
    localparam logic [4:0] LAST_RND = 5'(ROUNDS - 1);

    logic [1:0] state_r;
    logic [4:0] cnt_r;
    half_t      l_r;
    half_t      r_r;
    key_t       key_r;
    logic       in_ready_r;
    logic       out_valid_r;
    logic       busy_r;
    block_t     enc_r;

    block_t     blk_in_s;
    half_t      k_s;
    half_t      l_nxt_s;
    half_t      r_nxt_s;
    logic       accept_s;
    logic       deliver_s;

`ifdef MSG_ENCRYPTOR_CBC_EN
    block_t     chain_r;

    // Chain register follows every ciphertext handed downstream
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chain_r <= 64'h0;
        end else if (deliver_s) begin
            chain_r <= enc_r;
        end
    end

    // Whiten the plaintext with the previous ciphertext
    always_comb begin
        blk_in_s = message ^ chain_r;
    end
`else
    // Blocks are independent: plaintext enters the rounds unchanged
    always_comb begin
        blk_in_s = message;
    end
`endif

    // Handshake decodes and the subkey for the round in flight
    always_comb begin
        accept_s  = (state_r == S_IDLE) && in_valid;
        deliver_s = (state_r == S_DONE) && out_ready;
        k_s       = subkey(key_r, cnt_r);
    end

    msg_feistel_round u_round (
        .l      (l_r),
        .r      (r_r),
        .k      (k_s),
        .l_next (l_nxt_s),
        .r_next (r_nxt_s)
    );

    // Block FSM: latch on accept, iterate ROUNDS rounds, hold result until taken
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= S_IDLE;
            cnt_r       <= 5'd0;
            l_r         <= 32'h0;
            r_r         <= 32'h0;
            key_r       <= 64'h0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            enc_r       <= 64'h0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        l_r        <= blk_in_s[63:32];
                        r_r        <= blk_in_s[31:0];
                        key_r      <= key;
                        cnt_r      <= 5'd0;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= S_RUN;
                    end
                end
                S_RUN: begin
                    l_r <= l_nxt_s;
                    r_r <= r_nxt_s;
                    if (cnt_r == LAST_RND) begin
                        // final halves go out swapped so decryption reuses the same round
                        enc_r       <= {r_nxt_s, l_nxt_s};
                        out_valid_r <= 1'b1;
                        cnt_r       <= 5'd0;
                        state_r     <= S_DONE;
                    end else begin
                        cnt_r <= cnt_r + 5'd1;
                    end
                end
                S_DONE: begin
                    if (deliver_s) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= S_IDLE;
                    end
                end
                default: begin
                    state_r     <= S_IDLE;
                    cnt_r       <= 5'd0;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready      = in_ready_r;
    assign out_valid     = out_valid_r;
    assign encrypted_msg = enc_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_msg_encryptor.sv
// tb_msg_encryptor: randomized scoreboard bench for msg_encryptor (16-round instance)
// plus a directed single-round instance; honours MSG_ENCRYPTOR_CBC_EN when defined.
module tb_msg_encryptor;

    localparam int NR = 16;

    logic        clk = 1'b0;
    logic        reset;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
    logic [63:0] a_message, a_key, a_enc;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [63:0] b_message, b_key, b_enc;

    typedef struct {
        logic [63:0] msg;
        logic [63:0] key;
        logic [63:0] chain;
        logic [63:0] exp;
        int          acc;
    } item_t;

    item_t       sb_q[$];
    logic [63:0] got_q[$];
    logic [63:0] chain_m;
    bit          rand_ready;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    msg_encryptor #(.ROUNDS(NR)) dut (
        .clk(clk), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .message(a_message), .key(a_key),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .encrypted_msg(a_enc), .busy(a_busy)
    );

    msg_encryptor #(.ROUNDS(1)) dut_r1 (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .message(b_message), .key(b_key),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .encrypted_msg(b_enc), .busy(b_busy)
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] ks(input logic [63:0] k, input int i);
        int          s;
        logic [63:0] rk;
        s  = (4 * i) % 64;
        rk = (s == 0) ? k : ((k << s) | (k >> (64 - s)));
        return rk[31:0];
    endfunction

    function automatic logic [31:0] ff(input logic [31:0] r, input logic [31:0] k);
        logic [31:0] x;
        x = r ^ k;
        return ((x << 3) | (x >> 29)) + k;
    endfunction

    function automatic logic [63:0] ref_enc(input logic [63:0] m, input logic [63:0] k, input int nr);
        logic [31:0] l, r, t;
        l = m[63:32];
        r = m[31:0];
        for (int i = 0; i < nr; i++) begin
            t = r;
            r = l ^ ff(r, ks(k, i));
            l = t;
        end
        return {r, l};
    endfunction

    function automatic logic [63:0] ref_dec(input logic [63:0] c, input logic [63:0] k, input int nr);
        logic [31:0] l, r, t;
        l = c[63:32];
        r = c[31:0];
        for (int i = nr - 1; i >= 0; i--) begin
            t = r;
            r = l ^ ff(r, ks(k, i));
            l = t;
        end
        return {r, l};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    task automatic send16(input logic [63:0] m, input logic [63:0] k,
                          input bit use_exp, input logic [63:0] exp_c);
        item_t it;
        int    n;
        @(posedge clk); #1;
        a_in_valid = 1'b1;
        a_message  = m;
        a_key      = k;
        n = 0;
        @(negedge clk);
        while (!a_in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!a_in_ready) begin
            failures++;
            $display("FAIL accept_timeout actual=in_ready_low expected=accept");
        end else begin
            it.msg   = m;
            it.key   = k;
            it.chain = chain_m;
            it.exp   = use_exp ? exp_c : ref_enc(m ^ chain_m, k, NR);
            it.acc   = cyc;
`ifdef MSG_ENCRYPTOR_CBC_EN
            chain_m  = it.exp;
`endif
            sb_q.push_back(it);
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        a_message  = {$urandom, $urandom};
        a_key      = {$urandom, $urandom};
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout actual=%0d expected=0 pending", sb_q.size());
        end
    endtask

    // Random downstream backpressure when enabled
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_ready) a_out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic        prev_valid;
        logic        prev_hold;
        logic [63:0] prev_ct;
        item_t       it;
        prev_valid = 1'b0;
        prev_hold  = 1'b0;
        prev_ct    = 64'h0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_valid = 1'b0;
                prev_hold  = 1'b0;
            end else begin
                if (prev_hold) begin
                    check("hold_valid", 64'(a_out_valid), 64'd1);
                    check("hold_data", a_enc, prev_ct);
                end
                if (a_out_valid && !prev_valid && sb_q.size() != 0)
                    check("latency", 64'(cyc - sb_q[0].acc), 64'(NR + 1));
                if (a_out_valid && a_out_ready) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_output actual=%h expected=none", a_enc);
                    end else begin
                        it = sb_q.pop_front();
                        got_q.push_back(a_enc);
                        if (a_enc !== it.exp) begin
                            failures++;
                            $display("FAIL ciphertext actual=%h expected=%h", a_enc, it.exp);
                        end
                        check("round_trip", ref_dec(a_enc, it.key, NR) ^ it.chain, it.msg);
                    end
                end
                prev_valid = a_out_valid;
                prev_hold  = a_out_valid && !a_out_ready;
                prev_ct    = a_enc;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] m, k, hold, c0, e1, e2;
        int          n;
        reset = 1'b1;
        a_in_valid = 1'b0; a_message = 64'h0; a_key = 64'h0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_message = 64'h0; b_key = 64'h0; b_out_ready = 1'b1;
        rand_ready = 1'b0;
        chain_m = 64'h0;
        #2 reset = 1'b0;
        #1;
        check("reset_in_ready", 64'(a_in_ready), 64'd1);
        check("reset_out_valid", 64'(a_out_valid), 64'd0);
        check("reset_busy", 64'(a_busy), 64'd0);
        check("reset_enc", a_enc, 64'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // 16 rounds, all-zero key and plaintext
        send16(64'h0, 64'h0, 1'b1, 64'h0);
        drain();

        // single-round instance: exact value and one-cycle latency
        @(posedge clk); #1;
        b_in_valid = 1'b1; b_message = 64'h00000000_00000001; b_key = 64'h0;
        @(negedge clk);
        check("r1_in_ready", 64'(b_in_ready), 64'd1);
        @(posedge clk); #1 b_in_valid = 1'b0;
        @(negedge clk);
        check("r1_not_early", 64'(b_out_valid), 64'd0);
        check("r1_busy", 64'(b_busy), 64'd1);
        @(negedge clk);
        check("r1_valid", 64'(b_out_valid), 64'd1);
        check("r1_data", b_enc, 64'h00000008_00000001);
        @(negedge clk);
        check("r1_valid_drop", 64'(b_out_valid), 64'd0);
        check("r1_in_ready_back", 64'(b_in_ready), 64'd1);
        check("r1_data_retained", b_enc, 64'h00000008_00000001);

        // backpressure in DONE
        a_out_ready = 1'b0;
        send16({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 64'h0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!a_out_valid && n < 100);
        check("bp_out_valid_seen", 64'(a_out_valid), 64'd1);
        hold = a_enc;
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", 64'(a_out_valid), 64'd1);
            check("bp_data", a_enc, hold);
            check("bp_in_ready", 64'(a_in_ready), 64'd0);
        end
        @(posedge clk); #1 a_out_ready = 1'b1;
        @(posedge clk); #1 a_out_ready = 1'b0;
        @(negedge clk);
        check("bp_valid_drop", 64'(a_out_valid), 64'd0);
        check("bp_in_ready_rise", 64'(a_in_ready), 64'd1);
        check("bp_data_retained", a_enc, hold);
        a_out_ready = 1'b1;
        drain();

        // two identical plaintexts under one key
        m = {$urandom, $urandom};
        k = {$urandom, $urandom};
        c0 = chain_m;
        got_q.delete();
        send16(m, k, 1'b0, 64'h0);
        send16(m, k, 1'b0, 64'h0);
        drain();
        checks++;
        if (got_q.size() != 2) begin
            failures++;
            $display("FAIL pair_count actual=%0d expected=2", got_q.size());
        end else begin
            e1 = ref_enc(m ^ c0, k, NR);
`ifdef MSG_ENCRYPTOR_CBC_EN
            e2 = ref_enc(m ^ e1, k, NR);
            checks++;
            if (got_q[1] === got_q[0]) begin
                failures++;
                $display("FAIL cbc_differ actual=%h expected=not_%h", got_q[1], got_q[0]);
            end
`else
            e2 = e1;
`endif
            check("pair_first", got_q[0], e1);
            check("pair_second", got_q[1], e2);
        end

        // randomized round trip with random backpressure and idle gaps
        rand_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            send16({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 64'h0);
            if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
        end
        drain();

        // reset in the middle of a block aborts it
        rand_ready = 1'b0;
        a_out_ready = 1'b1;
        send16({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 64'h0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("mid_busy", 64'(a_busy), 64'd1);
        @(posedge clk); #2 reset = 1'b0;
        #1;
        check("abort_out_valid", 64'(a_out_valid), 64'd0);
        check("abort_in_ready", 64'(a_in_ready), 64'd1);
        check("abort_enc", a_enc, 64'h0);
        check("abort_busy", 64'(a_busy), 64'd0);
        sb_q.delete();
        chain_m = 64'h0;
        @(posedge clk); #1 reset = 1'b1;
        repeat (NR + 4) begin
            @(negedge clk);
            check("abort_no_output", 64'(a_out_valid), 64'd0);
        end
        send16({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 64'h0);
        drain();

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound
    initial begin
        #5000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
